pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage CPU pipeline (F, D, E, M, W). It sits beside the ALU forwarding unit and covers the hazards forwarding cannot resolve:
- load-use dependencies
- taken-branch redirects
- multi-cycle data-memory accesses

It drives per-stage stall and flush controls, watches the data-memory handshake with a timeout, and keeps saturating performance counters.

Parameters:
REG_W, 4, register-address width (16-entry register file)
MEM_TIMEOUT, 64, max consecutive wait cycles on a memory access before error
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-low reset
rs2_d  in  REG_W  decode-stage source register A
rs3_d  in  REG_W  decode-stage source register B
use_rs2_d  in  1  decode instruction reads rs2_d
use_rs3_d  in  1  decode instruction reads rs3_d
dest_e  in  REG_W  execute-stage destination register
regwrite_e  in  1  execute instruction writes dest_e
is_load_e  in  1  execute instruction is a load
branch_taken_e  in  1  execute stage resolved a taken branch/jump
mem_req_m  in  1  memory-stage instruction accesses data memory
mem_ready_m  in  1  data memory completes the access this cycle
stall_f  out  1  hold PC
stall_d  out  1  hold F/D register
stall_e  out  1  hold D/E register
stall_m  out  1  hold E/M register
flush_d  out  1  clear F/D register (bubble)
flush_e  out  1  clear D/E register (bubble)
flush_w  out  1  clear M/W register (bubble)
mem_err  out  1  sticky memory-timeout error
stall_cycles  out  CNT_W  cycles with stall_f=1, saturating
flush_count  out  CNT_W  branch-flush events, saturating

Behaviour:
- One clock, `clk`. Reset is synchronous, active-low (`rst`=0 at a rising edge).
- State values after reset:
  - FSM in RUN
  - wait counter = 0
  - mem_err = 0, stall_cycles = 0, flush_count = 0
- All stall/flush outputs are combinational from FSM state and the current inputs. With rst=0 they are all 0 except that, if the FSM was in ERROR, stalls stay asserted until the reset edge.
- FSM states:
  - RUN
    - mem_req_m & !mem_ready_m → MEM_WAIT, wait counter loaded with 1.
    - Otherwise stay in RUN.
  - MEM_WAIT
    - mem_ready_m → RUN.
    - Wait counter reaches MEM_TIMEOUT without mem_ready_m → ERROR.
    - Otherwise increment the wait counter.
  - ERROR: terminal until reset. mem_err=1; stall_f, stall_d, stall_e, stall_m held at 1; flush_w=1.
- Memory stall (highest priority). Applies in RUN when mem_req_m & !mem_ready_m, and in MEM_WAIT whenever !mem_ready_m.
  - stall_f = stall_d = stall_e = stall_m = 1, flush_w = 1.
  - flush_d = flush_e = 0. Branch and load-use detection are suppressed; branch_taken_e stays stable because E is frozen.
  - In the cycle mem_ready_m=1, no memory stall is asserted. The access completes with zero extra latency.
- Branch (second priority), when branch_taken_e with no memory stall:
  - flush_d = flush_e = 1 for that cycle, all stalls 0.
  - Load-use detection is ignored, since the decode instruction is squashed.
  - flush_count increments.
- Load-use (third priority). Condition: is_load_e & regwrite_e & ((use_rs2_d & rs2_d==dest_e) | (use_rs3_d & rs3_d==dest_e)).
  - stall_f = stall_d = 1, flush_e = 1.
  - Exactly one bubble; the next cycle the load is in M and is forwarded.
  - No register-zero exemption.
- stall_cycles increments each cycle stall_f=1, including in ERROR. Both counters saturate at 2^CNT_W−1.
- Reset asserted mid-MEM_WAIT or in ERROR returns to RUN at the next edge and clears everything.

Decomposition:
- Package hazard_pkg:
  - REG_W default constant
  - FSM enum hz_state_t {RUN, MEM_WAIT, ERROR}
  - struct hz_ctrl_t bundling the seven stall/flush bits, shared with the pipeline registers
- One sub-module, mem_wait_timer:
  - Wait counter and timeout compare.
  - Inputs: clk, rst, start, busy, ready.
  - Output: timeout pulse.
- Perf counters are inline in the top module.

Test Plan:
1. Load-use: is_load_e=1, regwrite_e=1, dest_e=5, use_rs2_d=1, rs2_d=5 for one cycle → stall_f=stall_d=flush_e=1 that cycle; next cycle (is_load_e=0) all 0; stall_cycles=1.
2. Branch beats load-use: same as scenario 1 plus branch_taken_e=1 → flush_d=flush_e=1, stall_f=0, flush_count=1, stall_cycles=0.
3. Memory wait: mem_req_m=1, mem_ready_m=0 for 3 cycles, then ready=1 → stalls+flush_w high for exactly 3 cycles, 0 on the ready cycle, state back to RUN, stall_cycles=3.
4. Memory stall masks branch: mem wait of 2 cycles with branch_taken_e=1 held → flush_d=0 during the wait; flush_d=flush_e=1 on the ready cycle; flush_count=1.
5. Timeout: MEM_TIMEOUT=4, mem_ready_m held 0 → mem_err=1 once the counter reaches 4, stalls stuck at 1 thereafter; assert rst=0 for one edge → mem_err=0, state RUN, counters 0.
6. Saturation: CNT_W=3, continuous load-use stall for 10 cycles → stall_cycles stops at 7.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the pipeline hazard controller.
//   REG_W_DEFAULT : default register-address width (16-entry register file)
//   hz_state_t    : sequencer states
//   hz_ctrl_t     : the seven stall/flush bits, shared with the pipeline registers
package hazard_pkg;

  localparam int unsigned REG_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } hz_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard-detection inputs and stall/flush/status outputs.
//   master : pipeline side (drives hazard inputs, receives controls)
//   slave  : hazard controller side
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned REG_W = 4,
  parameter int unsigned CNT_W = 16
) ();

  logic [REG_W-1:0] rs2_d;
  logic [REG_W-1:0] rs3_d;
  logic             use_rs2_d;
  logic             use_rs3_d;
  logic [REG_W-1:0] dest_e;
  logic             regwrite_e;
  logic             is_load_e;
  logic             branch_taken_e;
  logic             mem_req_m;
  logic             mem_ready_m;
  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             stall_m;
  logic             flush_d;
  logic             flush_e;
  logic             flush_w;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output rs2_d, rs3_d, use_rs2_d, use_rs3_d, dest_e, regwrite_e, is_load_e,
           branch_taken_e, mem_req_m, mem_ready_m,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_err,
           stall_cycles, flush_count
  );

  modport slave (
    input  rs2_d, rs3_d, use_rs2_d, use_rs3_d, dest_e, regwrite_e, is_load_e,
           branch_taken_e, mem_req_m, mem_ready_m,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_err,
           stall_cycles, flush_count
  );

endinterface

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive wait cycles of a data-memory access.
//   clk, rst : clock, synchronous active-low reset
//   start    : access stalls from idle; counter loads 1
//   busy     : sequencer is waiting on memory
//   ready    : memory completes this cycle
//   timeout  : waiting, not ready, and counter has reached MEM_TIMEOUT
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic busy,
  input  logic ready,
  output logic timeout
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MEM_TIMEOUT);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CntW'(1);
    end else if (busy) begin
      if (ready) begin
        cnt_d = '0;
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign timeout = busy & ~ready & (cnt_q == CntMax);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
//   clk, rst : clock, synchronous active-low reset
//   hz       : hazard inputs (decode sources, execute dest/load/branch, memory
//              handshake) and outputs (per-stage stall/flush, sticky mem_err,
//              saturating stall_cycles / flush_count)
// Priority: memory stall > taken branch > load-use.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W       = REG_W_DEFAULT,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  hz_state_t        state_q, state_d;
  hz_ctrl_t         ctrl;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic [REG_W-1:0] dest_e;
  logic             in_err, mem_start, mem_stall, load_use, branch_flush, timeout;

  assign dest_e    = hz.dest_e;
  assign in_err    = (state_q == ERROR);
  assign mem_start = (state_q == RUN) & hz.mem_req_m & ~hz.mem_ready_m;
  assign mem_stall = mem_start | ((state_q == MEM_WAIT) & ~hz.mem_ready_m);
  assign load_use  = hz.is_load_e & hz.regwrite_e &
                     ((hz.use_rs2_d & (hz.rs2_d == dest_e)) |
                      (hz.use_rs3_d & (hz.rs3_d == dest_e)));
  assign branch_flush = rst & ~in_err & ~mem_stall & hz.branch_taken_e;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (mem_start),
    .busy   (state_q == MEM_WAIT),
    .ready  (hz.mem_ready_m),
    .timeout(timeout)
  );

  always_comb begin
    ctrl = '0;
    if (!rst) begin
      // A hung memory keeps the pipeline frozen until the reset edge lands.
      if (in_err) begin
        ctrl.stall_f = 1'b1;
        ctrl.stall_d = 1'b1;
        ctrl.stall_e = 1'b1;
        ctrl.stall_m = 1'b1;
      end
    end else if (in_err || mem_stall) begin
      ctrl.stall_f = 1'b1;
      ctrl.stall_d = 1'b1;
      ctrl.stall_e = 1'b1;
      ctrl.stall_m = 1'b1;
      ctrl.flush_w = 1'b1;
    end else if (hz.branch_taken_e) begin
      ctrl.flush_d = 1'b1;
      ctrl.flush_e = 1'b1;
    end else if (load_use) begin
      ctrl.stall_f = 1'b1;
      ctrl.stall_d = 1'b1;
      ctrl.flush_e = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (mem_start) state_d = MEM_WAIT;
      MEM_WAIT: begin
        if (hz.mem_ready_m) state_d = RUN;
        else if (timeout)   state_d = ERROR;
      end
      ERROR:    state_d = ERROR;
      default:  state_d = RUN;
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (ctrl.stall_f && stall_cycles_q != CntMax) stall_cycles_d = stall_cycles_q + 1'b1;
    if (branch_flush && flush_count_q != CntMax)  flush_count_d  = flush_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= RUN;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign hz.stall_f      = ctrl.stall_f;
  assign hz.stall_d      = ctrl.stall_d;
  assign hz.stall_e      = ctrl.stall_e;
  assign hz.stall_m      = ctrl.stall_m;
  assign hz.flush_d      = ctrl.flush_d;
  assign hz.flush_e      = ctrl.flush_e;
  assign hz.flush_w      = ctrl.flush_w;
  assign hz.mem_err      = in_err;
  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl with small parameters (MEM_TIMEOUT=4, CNT_W=3)
// so timeout and counter saturation are reachable quickly.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned RW   = 4;
  localparam int unsigned TO   = 4;
  localparam int unsigned CW   = 3;
  localparam int          CMAX = (1 << CW) - 1;

  // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100010;
  localparam logic [6:0] C_BR   = 7'b0000110;
  localparam logic [6:0] C_MEM  = 7'b1111001;
  localparam logic [6:0] C_RERR = 7'b1111000;

  typedef struct packed {
    logic [3:0] rs2;
    logic [3:0] rs3;
    logic       u2;
    logic       u3;
    logic [3:0] dest;
    logic       rw;
    logic       ld;
    logic       br;
    logic       req;
    logic       rdy;
    logic [6:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_W(RW), .CNT_W(CW)) hz_if ();

  pipeline_hazard_ctrl #(
    .REG_W      (RW),
    .MEM_TIMEOUT(TO),
    .CNT_W      (CW)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .hz (hz_if)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: how many cycles the current access has waited (0 = none),
  // whether memory has timed out, and the two event counts.
  int m_wait;
  bit m_err;
  int m_sc;
  int m_fc;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] dut_ctrl();
    return {hz_if.stall_f, hz_if.stall_d, hz_if.stall_e, hz_if.stall_m,
            hz_if.flush_d, hz_if.flush_e, hz_if.flush_w};
  endfunction

  task automatic apply(input vec_t v);
    hz_if.rs2_d          = v.rs2;
    hz_if.rs3_d          = v.rs3;
    hz_if.use_rs2_d      = v.u2;
    hz_if.use_rs3_d      = v.u3;
    hz_if.dest_e         = v.dest;
    hz_if.regwrite_e     = v.rw;
    hz_if.is_load_e      = v.ld;
    hz_if.branch_taken_e = v.br;
    hz_if.mem_req_m      = v.req;
    hz_if.mem_ready_m    = v.rdy;
  endtask

  task automatic idle();
    vec_t v;
    v = '0;
    v.rdy = 1'b1;
    apply(v);
  endtask

  // One clock: compare outputs mid-cycle against the model (and optionally a
  // table entry), advance the model, then cross the rising edge.
  task automatic step(input string tag, input bit use_tbl, input logic [6:0] tbl_exp);
    logic [6:0] e;
    bit ms, lu;
    @(negedge clk);
    lu = hz_if.is_load_e && hz_if.regwrite_e &&
         ((hz_if.use_rs2_d && hz_if.rs2_d == hz_if.dest_e) ||
          (hz_if.use_rs3_d && hz_if.rs3_d == hz_if.dest_e));
    ms = (m_wait > 0) ? !hz_if.mem_ready_m : (hz_if.mem_req_m && !hz_if.mem_ready_m);
    if (!rst)                   e = m_err ? C_RERR : C_NONE;
    else if (m_err || ms)       e = C_MEM;
    else if (hz_if.branch_taken_e) e = C_BR;
    else if (lu)                e = C_LU;
    else                        e = C_NONE;
    chk({tag, " ctrl"}, 32'(dut_ctrl()), 32'(e));
    if (use_tbl) chk({tag, " table"}, 32'(dut_ctrl()), 32'(tbl_exp));
    chk({tag, " mem_err"}, 32'(hz_if.mem_err), 32'(m_err));
    chk({tag, " stall_cycles"}, 32'(hz_if.stall_cycles), 32'(m_sc));
    chk({tag, " flush_count"}, 32'(hz_if.flush_count), 32'(m_fc));
    if (!rst) begin
      m_wait = 0; m_err = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (e[6] && m_sc < CMAX) m_sc++;
      if (!m_err && !ms && hz_if.branch_taken_e && m_fc < CMAX) m_fc++;
      if (!m_err) begin
        if (m_wait == 0) begin
          if (hz_if.mem_req_m && !hz_if.mem_ready_m) m_wait = 1;
        end else if (hz_if.mem_ready_m) m_wait = 0;
        else if (m_wait == TO)          m_err = 1;
        else                            m_wait++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    step("reset", 1'b0, C_NONE);
    rst = 1'b1;
  endtask

  initial begin
    vec_t v;
    //           rs2   rs3   u2 u3 dest  rw ld br req rdy exp
    vecs[0] = '{4'd1, 4'd2, 1, 1, 4'd3, 1, 1, 0, 0, 1, C_NONE};
    vecs[1] = '{4'd5, 4'd0, 1, 0, 4'd5, 1, 1, 0, 0, 1, C_LU};
    vecs[2] = '{4'd0, 4'd7, 0, 1, 4'd7, 1, 1, 0, 0, 1, C_LU};
    vecs[3] = '{4'd5, 4'd0, 0, 0, 4'd5, 1, 1, 0, 0, 1, C_NONE};
    vecs[4] = '{4'd5, 4'd5, 1, 1, 4'd5, 0, 1, 0, 0, 1, C_NONE};
    vecs[5] = '{4'd5, 4'd5, 1, 1, 4'd5, 1, 0, 0, 0, 1, C_NONE};
    vecs[6] = '{4'd5, 4'd0, 1, 0, 4'd5, 1, 1, 1, 0, 1, C_BR};
    vecs[7] = '{4'd0, 4'd0, 1, 0, 4'd0, 1, 1, 0, 0, 1, C_LU};
    vecs[8] = '{4'd5, 4'd0, 1, 0, 4'd5, 1, 1, 0, 1, 1, C_LU};
    vecs[9] = '{4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 1, 1, 1, C_BR};

    // Bring registers out of X before any checking.
    idle();
    rst = 1'b0;
    @(posedge clk);
    #1;
    m_wait = 0; m_err = 0; m_sc = 0; m_fc = 0;
    rst = 1'b1;
    step("post_reset", 1'b1, C_NONE);

    // Single-cycle table from RUN.
    for (int i = 0; i < 10; i++) begin
      apply(vecs[i]);
      step($sformatf("vec%0d", i), 1'b1, vecs[i].exp);
    end

    // Load-use: one bubble, then clear.
    do_reset();
    apply(vecs[1]);
    step("lu", 1'b1, C_LU);
    idle();
    step("lu_next", 1'b1, C_NONE);
    chk("lu stall_cycles", 32'(hz_if.stall_cycles), 32'd1);

    // Branch beats load-use.
    do_reset();
    apply(vecs[6]);
    step("br_lu", 1'b1, C_BR);
    idle();
    step("br_next", 1'b1, C_NONE);
    chk("br flush_count", 32'(hz_if.flush_count), 32'd1);
    chk("br stall_cycles", 32'(hz_if.stall_cycles), 32'd0);

    // Memory wait of 3 cycles, zero latency on the ready cycle.
    do_reset();
    v = '0;
    v.req = 1'b1;
    apply(v);
    for (int i = 0; i < 3; i++) step("memw", 1'b1, C_MEM);
    hz_if.mem_ready_m = 1'b1;
    step("memw_rdy", 1'b1, C_NONE);
    idle();
    step("memw_after", 1'b1, C_NONE);
    chk("memw stall_cycles", 32'(hz_if.stall_cycles), 32'd3);

    // Memory stall masks a held branch until the ready cycle.
    do_reset();
    v = '0;
    v.req = 1'b1;
    v.br  = 1'b1;
    apply(v);
    for (int i = 0; i < 2; i++) step("mem_br", 1'b1, C_MEM);
    hz_if.mem_ready_m = 1'b1;
    step("mem_br_rdy", 1'b1, C_BR);
    idle();
    step("mem_br_after", 1'b1, C_NONE);
    chk("mem_br flush_count", 32'(hz_if.flush_count), 32'd1);

    // Timeout into ERROR, then reset recovers.
    do_reset();
    v = '0;
    v.req = 1'b1;
    apply(v);
    for (int i = 0; i < 8; i++) step("tmo", 1'b1, C_MEM);
    chk("tmo mem_err", 32'(hz_if.mem_err), 32'd1);
    rst = 1'b0;
    step("tmo_rst", 1'b1, C_RERR);
    rst = 1'b1;
    idle();
    chk("tmo_rst mem_err", 32'(hz_if.mem_err), 32'd0);
    chk("tmo_rst stall_cycles", 32'(hz_if.stall_cycles), 32'd0);
    step("tmo_after", 1'b1, C_NONE);

    // Saturation of stall_cycles at 2^CNT_W-1.
    do_reset();
    apply(vecs[1]);
    for (int i = 0; i < 10; i++) step("sat", 1'b1, C_LU);
    chk("sat stall_cycles", 32'(hz_if.stall_cycles), 32'(CMAX));

    // Randomised traffic against the model, with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      v.rs2  = 4'($urandom_range(0, 3));
      v.rs3  = 4'($urandom_range(0, 3));
      v.u2   = 1'($urandom);
      v.u3   = 1'($urandom);
      v.dest = 4'($urandom_range(0, 3));
      v.rw   = 1'($urandom);
      v.ld   = 1'($urandom);
      v.br   = ($urandom_range(0, 3) == 0);
      v.req  = 1'($urandom);
      v.rdy  = ($urandom_range(0, 2) != 0);
      v.exp  = C_NONE;
      apply(v);
      rst = ($urandom_range(0, 99) != 0);
      step("rand", 1'b0, C_NONE);
    end
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
